// File: rtl/enemy_patrol.sv
// Per-enemy motion and life-cycle controller, advanced once per frame tick.
// Patrols a clamped box on one or both axes, takes multi-hit damage with a stun window, parks when dead.
module enemy_patrol #(
  parameter int X_MIN          = 255,
  parameter int X_MAX          = 350,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 479,
  parameter int X_START        = 300,
  parameter int Y_START        = 240,
  parameter int SIZE           = 30,
  parameter int STEP           = 1,
  parameter int MODE           = 0,
  parameter int HP             = 3,
  parameter int IFRAMES        = 16,
  parameter int RESPAWN_FRAMES = 0,
  parameter int PARK_X         = 700,
  parameter int PARK_Y         = 500
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       enable,
  input  logic       hit,
  output logic [9:0] enemy_X,
  output logic [9:0] enemy_Y,
  output logic [9:0] enemy_S,
  output logic [3:0] hp,
  output logic       alive,
  output logic       flash,
  output logic       debug_enemy_dead
);

  localparam logic [1:0] ST_PATROL = 2'd0;
  localparam logic [1:0] ST_STUN   = 2'd1;
  localparam logic [1:0] ST_DEAD   = 2'd2;

  localparam logic [10:0] X_LO   = 11'(X_MIN + SIZE);
  localparam logic [10:0] X_HI   = 11'(X_MAX - SIZE);
  localparam logic [10:0] Y_LO   = 11'(Y_MIN + SIZE);
  localparam logic [10:0] Y_HI   = 11'(Y_MAX - SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);

  localparam logic MOVE_X = (MODE == 0) || (MODE == 2);
  localparam logic MOVE_Y = (MODE == 1) || (MODE == 2);

  localparam logic [15:0] STUN_LOAD = 16'(IFRAMES - 1);
  localparam logic [15:0] DEAD_LOAD = 16'(RESPAWN_FRAMES - 1);
  localparam logic        RESPAWNS  = (RESPAWN_FRAMES != 0);

  logic [1:0]  r_state;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_dx;
  logic        r_dy;
  logic [3:0]  r_hp;
  logic [15:0] r_timer;
  logic [15:0] r_dead_cnt;

  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic        w_reload;

  // Returns {new direction, new position}; direction 1 means moving towards HI.
  function automatic logic [10:0] f_bounce(input logic [9:0] pos, input logic dir,
                                           input logic [10:0] lo, input logic [10:0] hi);
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] d;
    logic [10:0] r;
    p = {1'b0, pos};
    s = p + STEP11;
    d = p - STEP11;
    if (dir) begin
      if (s >= hi) r = {1'b0, hi[9:0]};
      else         r = {1'b1, s[9:0]};
    end else begin
      if (p <= lo + STEP11) r = {1'b1, lo[9:0]};
      else                  r = {1'b0, d[9:0]};
    end
    return r;
  endfunction

  always_comb begin
    w_bx     = f_bounce(r_x, r_dx, X_LO, X_HI);
    w_by     = f_bounce(r_y, r_dy, Y_LO, Y_HI);
    w_reload = !Reset_n ||
               (enable && RESPAWNS && (r_state == ST_DEAD) && (r_dead_cnt == 16'd0));
  end

  // Respawn shares the reset load path so both land on identical values.
  always_ff @(posedge frame_clk) begin
    if (w_reload) begin
      r_state    <= ST_PATROL;
      r_x        <= 10'(X_START);
      r_y        <= 10'(Y_START);
      r_dx       <= 1'b1;
      r_dy       <= 1'b1;
      r_hp       <= 4'(HP);
      r_timer    <= 16'd0;
      r_dead_cnt <= 16'd0;
    end else if (enable) begin
      case (r_state)
        ST_PATROL: begin
          if (hit) begin
            if (r_hp == 4'd1) begin
              r_hp       <= 4'd0;
              r_state    <= ST_DEAD;
              r_dead_cnt <= DEAD_LOAD;
              r_x        <= 10'(PARK_X);
              r_y        <= 10'(PARK_Y);
            end else begin
              r_hp    <= r_hp - 4'd1;
              r_timer <= STUN_LOAD;
              r_state <= ST_STUN;
            end
          end else begin
            if (MOVE_X) begin
              r_dx <= w_bx[10];
              r_x  <= w_bx[9:0];
            end
            if (MOVE_Y) begin
              r_dy <= w_by[10];
              r_y  <= w_by[9:0];
            end
          end
        end
        ST_STUN: begin
          if (r_timer == 16'd0) r_state <= ST_PATROL;
          else                  r_timer <= r_timer - 16'd1;
        end
        ST_DEAD: begin
          if (RESPAWNS) r_dead_cnt <= r_dead_cnt - 16'd1;
        end
        default: r_state <= ST_PATROL;
      endcase
    end
  end

  assign enemy_X          = r_x;
  assign enemy_Y          = r_y;
  assign enemy_S          = 10'(SIZE);
  assign hp               = r_hp;
  assign alive            = (r_state != ST_DEAD);
  assign flash            = (r_state == ST_STUN) && r_timer[2];
  assign debug_enemy_dead = (r_state == ST_DEAD);

endmodule
